// File: rtl/hog_block_assembler_if.sv
// Stream bundle for the HOG block assembler.
//   in_valid/in_ready/in_hist             : cell-histogram input stream
//   out_valid/out_ready/out_block/out_sum/out_last : 2x2 block output stream
// slave  = the assembler side, master = the producer/consumer side.
interface hog_block_assembler_if #(
  parameter int BIN_WIDTH = 14,
  parameter int BINS      = 10
);
  localparam int HIST_WIDTH  = BIN_WIDTH * BINS;
  localparam int BLOCK_WIDTH = 4 * HIST_WIDTH;

  logic                   in_valid;
  logic                   in_ready;
  logic [HIST_WIDTH-1:0]  in_hist;
  logic                   out_valid;
  logic                   out_ready;
  logic [BLOCK_WIDTH-1:0] out_block;
  logic [BIN_WIDTH+1:0]   out_sum;
  logic                   out_last;

  modport slave (
    input  in_valid, in_hist, out_ready,
    output in_ready, out_valid, out_block, out_sum, out_last
  );

  modport master (
    output in_valid, in_hist, out_ready,
    input  in_ready, out_valid, out_block, out_sum, out_last
  );
endinterface

// File: rtl/hog_block_assembler.sv
// HOG block assembler: consumes cell histograms in raster order, keeps one
// cell row in a line buffer and emits every overlapping 2x2 block (stride 1)
// together with the sum of the four cells' sum bins.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - hog_block_assembler_if.slave (input cell stream, output block stream)
// Block layout: [0+:H]=top-left, [H+:H]=top-right, [2H+:H]=bottom-left,
// [3H+:H]=bottom-right. Latency 1 from the accepting edge.
module hog_block_assembler #(
  parameter int BIN_WIDTH    = 14,
  parameter int BINS         = 10,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input logic                  clk,
  input logic                  rst,
  hog_block_assembler_if.slave bus
);
  localparam int CELLS_PER_ROW = IMAGE_WIDTH / 8;
  localparam int CELL_ROWS     = IMAGE_HEIGHT / 8;
  localparam int HIST_WIDTH    = BIN_WIDTH * BINS;
  localparam int SUM_WIDTH     = BIN_WIDTH + 2;
  localparam int SUM_LSB       = (BINS - 1) * BIN_WIDTH;
  localparam int COL_W         = (CELLS_PER_ROW > 1) ? $clog2(CELLS_PER_ROW) : 1;
  localparam int ROW_W         = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;

  logic [COL_W-1:0]              col;
  logic [ROW_W-1:0]              row;
  logic [HIST_WIDTH-1:0]         linebuf [CELLS_PER_ROW];
  logic [HIST_WIDTH-1:0]         top, left_q, topleft_q;
  logic [3:0][HIST_WIDTH-1:0]    blk;
  logic [SUM_WIDTH-1:0]          blk_sum;
  logic                          accept, emit, col_end, row_end;

  // The output register is the only stage, so it may take a new block
  // whenever it is empty or being drained this same cycle.
  assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Asynchronous read of the previous row before this accept overwrites it.
  assign top     = linebuf[col];
  assign col_end = (col == COL_W'(CELLS_PER_ROW - 1));
  assign row_end = (row == ROW_W'(CELL_ROWS - 1));
  assign emit    = (row != '0) && (col != '0);
  assign blk     = {bus.in_hist, left_q, top, topleft_q};

  // Four zero-extended sum bins cannot exceed BIN_WIDTH+2 bits.
  always_comb begin
    blk_sum = '0;
    for (int i = 0; i < 4; i++)
      blk_sum = blk_sum + SUM_WIDTH'(blk[i][SUM_LSB +: BIN_WIDTH]);
  end

  // Line buffer has no reset: every entry is rewritten during row 0 before
  // row 1 reads it.
  always_ff @(posedge clk) begin
    if (accept) linebuf[col] <= bus.in_hist;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      left_q        <= '0;
      topleft_q     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_block <= '0;
      bus.out_sum   <= '0;
    end else begin
      if (accept) begin
        left_q    <= bus.in_hist;
        topleft_q <= top;   // becomes top-left for the next column
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept && emit) begin
        bus.out_valid <= 1'b1;
        bus.out_block <= blk;
        bus.out_sum   <= blk_sum;
        bus.out_last  <= col_end && row_end;
      end else if (bus.out_ready) begin
        // Block/sum are left as-is; only the qualifiers drop.
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end
endmodule
